regfile_dump: RTL

Debug read-out engine for the MIPS register bank. It drives one asynchronous read port of the register file and walks a programmed register range. Each 32-bit register value is streamed out as bytes over a valid/ready byte interface, MSB first, for consumption by a UART/debug transmitter. It sits beside the register bank in the core top level and never writes the register file.

---
 rtl/regfile_dump_if.sv | 19 +
 rtl/regfile_dump.sv | 107 ++++++++++
 2 files changed

// File: rtl/regfile_dump_if.sv
// Byte stream handshake between the register dump engine and its transmitter.
// master drives tx_data/tx_valid, slave returns tx_ready.
interface regfile_dump_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// Register bank debug dump: walks a register range, streams each word MSB first.
// Option REGFILE_DUMP_ADDR_EN prefixes every word with an address byte.
module regfile_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  regfile_dump_if.master    tx,
  output logic              busy,
  output logic              done
);

  localparam int BYTES = DATA_W / 8;
`ifdef REGFILE_DUMP_ADDR_EN
  localparam int NB = BYTES + 1;
`else
  localparam int NB = BYTES;
`endif
  localparam int SH_W  = NB * 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FIN
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last;
  logic [SH_W-1:0]   sh;
  logic [CNT_W-1:0]  cnt;
  logic              hs;
  logic              last_byte;
  logic [SH_W-1:0]   load;

  assign hs        = (state == SEND) && tx.tx_ready;
  assign last_byte = (cnt == '0);

`ifdef REGFILE_DUMP_ADDR_EN
  assign load = {8'(cur), rf_rdata};
`else
  assign load = rf_rdata;
`endif

  // Read port follows cur; cur only moves when entering READ.
  assign rf_raddr    = cur;
  assign tx.tx_valid = (state == SEND);
  assign tx.tx_data  = sh[SH_W-1 -: 8];
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state decode.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = READ;
      READ: nxt = SEND;
      SEND: begin
        if (hs && last_byte)
          nxt = (cur == last) ? FIN : READ;
      end
      FIN:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Range pointers, snapshot shifter and byte counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur  <= '0;
      last <= '0;
      sh   <= '0;
      cnt  <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        cur  <= first_reg;
        last <= last_reg;
      end
      if (state == READ) begin
        sh  <= load;
        cnt <= CNT_W'(NB - 1);
      end
      if (hs) begin
        sh  <= sh << 8;
        cnt <= cnt - 1'b1;
        if (last_byte && (cur != last))
          cur <= cur + 1'b1;
      end
    end
  end

endmodule
